// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the two-digit 7-segment display.
//  Revision : 1.0  initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Segment patterns, bit 0 = a ... bit 6 = g, active high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [6:0] MAX_DISPLAY = 7'd99;

    // Double-dabble nibble correction; wraps mod 16 by construction
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_display_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decoder
//  Purpose  : Combinational BCD nibble to common-cathode segment pattern.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_display.sv
`default_nettype none
// ============================================================================
//  Module   : seven_segment_display
//  Purpose  : Binary-to-BCD conversion and two-digit multiplexed segment drive.
//  Revision : 1.0  initial release
// ============================================================================
module seven_segment_display
    import display_pkg::*;
#(
    parameter int REFRESH_PERIOD = 100 - 1,
    parameter int REFRESH_BITS   = 7
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] count,
    input  logic       load,
    output logic [6:0] segments,
    output logic       digit,
    output logic       busy,
    output logic       overflow,
    output logic [1:0] dbg_state
);

    localparam logic [REFRESH_BITS-1:0] C_REFRESH_LAST = REFRESH_BITS'(REFRESH_PERIOD);
    localparam logic [REFRESH_BITS-1:0] C_REFRESH_ONE  = REFRESH_BITS'(1);

    state_t                  r_state;
    logic [6:0]              r_bin;
    logic [6:0]              r_value;
    logic [7:0]              r_bcd;
    logic [2:0]              r_bit_cnt;
    logic [6:0]              r_pending_val;
    logic                    r_pending;
    logic [3:0]              r_tens;
    logic [3:0]              r_units;
    logic                    r_ovf;
    logic                    r_busy;
    logic [REFRESH_BITS-1:0] r_refresh_cnt;
    logic                    r_digit;

    logic [7:0]              w_bcd_adj;
    logic [3:0]              w_sel_nibble;
    logic [6:0]              w_dec_seg;
    logic                    w_take_pending;

    assign w_bcd_adj = {add3(r_bcd[7:4]), add3(r_bcd[3:0])};

    // A load seen during LOAD/SHIFT is parked; last value wins
    assign w_take_pending = load && ((r_state == LOAD) || (r_state == SHIFT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bin         <= '0;
            r_value       <= '0;
            r_bcd         <= '0;
            r_bit_cnt     <= '0;
            r_pending_val <= '0;
            r_pending     <= 1'b0;
            r_tens        <= '0;
            r_units       <= '0;
            r_ovf         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin   <= count;
                        r_value <= count;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_bcd     <= '0;
                    r_bit_cnt <= 3'd6;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    r_bcd <= {w_bcd_adj[6:0], r_bin[6]};
                    r_bin <= {r_bin[5:0], 1'b0};
                    if (r_bit_cnt == 3'd0) begin
                        r_state <= COMMIT;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 3'd1;
                    end
                end
                COMMIT: begin
                    r_tens  <= r_bcd[7:4];
                    r_units <= r_bcd[3:0];
                    r_ovf   <= (r_value > MAX_DISPLAY);
                    // A load arriving on this very cycle is newer than any parked value
                    if (load || r_pending) begin
                        r_bin     <= load ? count : r_pending_val;
                        r_value   <= load ? count : r_pending_val;
                        r_pending <= 1'b0;
                        r_state   <= LOAD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_take_pending) begin
                r_pending     <= 1'b1;
                r_pending_val <= count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit       <= 1'b0;
        end else if (r_refresh_cnt == C_REFRESH_LAST) begin
            r_refresh_cnt <= '0;
            r_digit       <= ~r_digit;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + C_REFRESH_ONE;
        end
    end

    assign w_sel_nibble = r_digit ? r_tens : r_units;

    seg7_decoder u_decoder (
        .bcd (w_sel_nibble),
        .seg (w_dec_seg)
    );

    assign segments  = r_ovf ? SEG_DASH : w_dec_seg;
    assign digit     = r_digit;
    assign busy      = r_busy;
    assign overflow  = r_ovf;
    assign dbg_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seven_segment_display
//  Purpose  : Directed self-checking bench with a commit-ordered scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_segment_display;
    import display_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] count;
    logic       load;
    logic [6:0] segments;
    logic       digit;
    logic       busy;
    logic       overflow;
    logic [1:0] dbg_state;
    logic [6:0] d_segments;
    logic       d_digit;
    logic       d_busy;
    logic       d_overflow;
    logic [1:0] d_dbg_state;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   m_cnt = 0;
    logic m_dig = 1'b0;
    logic armed = 1'b0;
    logic prev_commit = 1'b0;

    seven_segment_display #(.REFRESH_PERIOD(3), .REFRESH_BITS(2)) u_dut (
        .clk (clk), .reset (reset), .count (count), .load (load),
        .segments (segments), .digit (digit), .busy (busy),
        .overflow (overflow), .dbg_state (dbg_state)
    );

    seven_segment_display u_def (
        .clk (clk), .reset (reset), .count (count), .load (load),
        .segments (d_segments), .digit (d_digit), .busy (d_busy),
        .overflow (d_overflow), .dbg_state (d_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int n);
        case (n)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t mk_exp(input int v);
        exp_t e;
        e.ovf   = (v > 99);
        e.tens  = e.ovf ? 4'd0 : 4'(v / 10);
        e.units = e.ovf ? 4'd0 : 4'(v % 10);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic note_fail(input string tag);
        total++;
        $error("FAIL %s: observed no event within bound, expected event", tag);
    endtask

    // Display model: shown value changes only on the cycle after COMMIT
    always @(negedge clk) begin
        if (reset) begin
            armed = 1'b1;
            cur   = '0;
            sb_q.delete();
            m_cnt = 0;
            m_dig = 1'b0;
        end else if (armed) begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_dig = ~m_dig;
            end else begin
                m_cnt++;
            end
            if (prev_commit) begin
                if (sb_q.size() == 0) note_fail("sb_underflow");
                else cur = sb_q.pop_front();
            end
        end
        if (armed) begin
            chk("mon_digit", 32'(digit), 32'(m_dig));
            chk("mon_overflow", 32'(overflow), 32'(cur.ovf));
            chk("mon_segments", 32'(segments),
                32'(cur.ovf ? 7'b1000000 : seg_ref(m_dig ? int'(cur.tens) : int'(cur.units))));
        end
        prev_commit = !reset && (dbg_state == COMMIT);
    end

    task automatic do_load(input int v, input bit shown);
        @(negedge clk); #1;
        count = 7'(v);
        load  = 1'b1;
        if (shown) sb_q.push_back(mk_exp(v));
        @(negedge clk); #1;
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) note_fail(tag);
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n = 0;
        while (dbg_state !== st && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 30) note_fail(tag);
    endtask

    task automatic wait_digit(input logic v, input string tag);
        int n = 0;
        while (digit !== v && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 20) note_fail(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        int n_tog;
        reset = 1'b1;
        count = '0;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Test 1: idle display, default refresh period
        chk("t1_def_segments", 32'(d_segments), 32'(7'b0111111));
        chk("t1_def_busy", 32'(d_busy), 32'd0);
        chk("t1_def_overflow", 32'(d_overflow), 32'd0);
        chk("t1_def_digit", 32'(d_digit), 32'd0);
        n_tog = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk); #1;
            if (d_digit !== 1'b0) begin
                n_tog = i;
                break;
            end
        end
        chk("t1_first_toggle", 32'(n_tog), 32'd100);
        chk("t1_def_seg_tens", 32'(d_segments), 32'(7'b0111111));
        n_tog = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk); #1;
            if (d_digit !== 1'b1) begin
                n_tog = i;
                break;
            end
        end
        chk("t1_second_toggle", 32'(n_tog), 32'd100);

        // Test 2: single conversion latency and busy window
        do_load(42, 1'b1);
        chk("t2_busy_e0", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            chk("t2_busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk); #1;
        chk("t2_busy_done", 32'(busy), 32'd0);
        wait_digit(1'b1, "t2_wait_d1");
        chk("t2_seg_tens", 32'(segments), 32'(7'b1100110));
        wait_digit(1'b0, "t2_wait_d0");
        chk("t2_seg_units", 32'(segments), 32'(7'b1011011));

        // Test 3: loads while busy, last pending value wins
        do_load(7, 1'b1);
        n_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) n_hi++;
            else break;
            if (i == 1) begin
                count = 7'd58;
                load  = 1'b1;
            end else if (i == 3) begin
                count = 7'd93;
                load  = 1'b1;
                sb_q.push_back(mk_exp(93));
            end else begin
                load = 1'b0;
            end
            @(negedge clk); #1;
        end
        chk("t3_busy_span", 32'(n_hi), 32'd18);

        // Test 4: overflow dash and recovery
        do_load(100, 1'b1);
        wait_idle("t4_idle_100");
        chk("t4_ovf_100", 32'(overflow), 32'd1);
        wait_digit(1'b1, "t4_wait_d1");
        chk("t4_dash_tens", 32'(segments), 32'(7'b1000000));
        wait_digit(1'b0, "t4_wait_d0");
        chk("t4_dash_units", 32'(segments), 32'(7'b1000000));
        do_load(127, 1'b1);
        wait_idle("t4_idle_127");
        chk("t4_ovf_127", 32'(overflow), 32'd1);
        do_load(99, 1'b1);
        wait_idle("t4_idle_99");
        chk("t4_ovf_99", 32'(overflow), 32'd0);
        wait_digit(1'b1, "t4_wait_99");
        chk("t4_seg_9", 32'(segments), 32'(7'b1101111));

        // Test 5a: load on the COMMIT cycle
        do_load(23, 1'b1);
        wait_state(2'(COMMIT), "t5_wait_commit");
        count = 7'd64;
        load  = 1'b1;
        sb_q.push_back(mk_exp(64));
        @(negedge clk); #1;
        load  = 1'b0;
        chk("t5_busy_chain", 32'(busy), 32'd1);
        wait_idle("t5_idle_64");
        chk("t5_state_idle", 32'(dbg_state), 32'(IDLE));

        // Test 5b: reset mid-SHIFT with a pending value
        do_load(88, 1'b1);
        wait_state(2'(SHIFT), "t5_wait_shift");
        do_load(55, 1'b0);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        chk("t5_rst_state", 32'(dbg_state), 32'(IDLE));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            chk("t5_rst_stay_idle", 32'(dbg_state), 32'(IDLE));
        end
        do_load(11, 1'b1);
        wait_idle("t5_idle_11");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            chk("t5_no_stale_pending", 32'(busy), 32'd0);
        end

        // Test 6: every displayable value against the reference BCD model
        for (int v = 0; v <= 99; v++) begin
            do_load(v, 1'b1);
            wait_idle("t6_idle");
        end
        repeat (8) @(negedge clk);
        #1;
        chk("t6_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
